accum_datapath: RTL and testbench

//   Datapath and storage driven by the block-accumulate controller. Owns:
//   - a DEPTH-word data memory;
//   - the read-latency pipeline;
//   - register B (load) and accumulator A (clear / transfer).

---
 rtl/accum_datapath_if.sv | 43 ++++
 rtl/accum_datapath.sv | 139 +++++++++++++
 tb/tb_accum_datapath.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/accum_datapath_if.sv
// Bus between the block-accumulate controller (and the memory loader) and
// the accumulate datapath.
//   master : controller side, drives the request/strobe signals and observes status
//   slave  : datapath side, consumes the strobes and drives data/status outputs
// Signals
//   address/read_enable/load/clear/transfer/write_enable : controller strobes
//   init_we/init_addr/init_data                          : loader write port
//   rd_data/rd_valid/reg_b/acc                           : datapath state
//   overflow/load_err/init_collide                       : sticky status flags
interface accum_datapath_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5,
  parameter int ACC_W  = 11
);
  logic [ADDR_W-1:0] address;
  logic              read_enable;
  logic              load;
  logic              clear;
  logic              transfer;
  logic              write_enable;
  logic              init_we;
  logic [ADDR_W-1:0] init_addr;
  logic [DATA_W-1:0] init_data;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic [DATA_W-1:0] reg_b;
  logic [ACC_W-1:0]  acc;
  logic              overflow;
  logic              load_err;
  logic              init_collide;

  modport master (
    output address, read_enable, load, clear, transfer, write_enable,
    output init_we, init_addr, init_data,
    input  rd_data, rd_valid, reg_b, acc, overflow, load_err, init_collide
  );

  modport slave (
    input  address, read_enable, load, clear, transfer, write_enable,
    input  init_we, init_addr, init_data,
    output rd_data, rd_valid, reg_b, acc, overflow, load_err, init_collide
  );
endinterface

// File: rtl/accum_datapath.sv
// Block-accumulate datapath: DEPTH-word memory, fixed-latency read pipeline,
// operand register B and accumulator A with write-back of the truncated sum.
// Ports
//   i_clk : rising-edge clock
//   i_rst : synchronous active-high reset (memory contents are kept)
//   bus   : accum_datapath_if.slave carrying controller strobes, loader
//           write port, read data/valid, RegB, Acc and sticky status flags
module accum_datapath #(
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 5,
  parameter int DEPTH      = 32,
  parameter int RD_LATENCY = 2,
  parameter int ACC_W      = 11
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  accum_datapath_if.slave        bus
);

  function automatic logic [DATA_W-1:0] acc_trunc(input logic [ACC_W-1:0] a);
    return a[DATA_W-1:0];
  endfunction

  function automatic logic acc_exceeds(input logic [ACC_W-1:0] a);
    return |a[ACC_W-1:DATA_W];
  endfunction

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rd_data;
  logic              r_rd_valid;
  logic [DATA_W-1:0] r_reg_b;
  logic [ACC_W-1:0]  r_acc;
  logic              r_overflow;
  logic              r_load_err;
  logic              r_init_collide;

  logic [DATA_W-1:0] w_mem_rd;
  logic [DATA_W-1:0] w_done_data;
  logic              w_done_vld;

  // Asynchronous array read sampled at the request edge; since the write
  // lands at the same edge, a same-address read returns the old word.
  assign w_mem_rd = r_mem[bus.address];

  // ---- stage p0..pN: read latency pipeline ----
  generate
    if (RD_LATENCY == 1) begin : g_lat1
      assign w_done_vld  = bus.read_enable;
      assign w_done_data = w_mem_rd;
    end else begin : g_latn
      logic [DATA_W-1:0] r_data_p [RD_LATENCY-1];
      logic              r_vld_p  [RD_LATENCY-1];

      always_ff @(posedge i_clk) begin
        r_data_p[0] <= w_mem_rd;
        for (int i = 1; i < RD_LATENCY-1; i++) begin
          r_data_p[i] <= r_data_p[i-1];
        end
      end

      always_ff @(posedge i_clk) begin
        if (i_rst) begin
          for (int i = 0; i < RD_LATENCY-1; i++) begin
            r_vld_p[i] <= 1'b0;
          end
        end else begin
          r_vld_p[0] <= bus.read_enable;
          for (int i = 1; i < RD_LATENCY-1; i++) begin
            r_vld_p[i] <= r_vld_p[i-1];
          end
        end
      end

      assign w_done_vld  = r_vld_p[RD_LATENCY-2];
      assign w_done_data = r_data_p[RD_LATENCY-2];
    end
  endgenerate

  // ---- output stage: read data holds until a newer read completes ----
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else if (w_done_vld) begin
      r_rd_data  <= w_done_data;
      r_rd_valid <= 1'b1;
    end else if (bus.load) begin
      r_rd_valid <= 1'b0;
    end
  end

  // ---- register B / accumulator / status ----
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_reg_b        <= '0;
      r_acc          <= '0;
      r_overflow     <= 1'b0;
      r_load_err     <= 1'b0;
      r_init_collide <= 1'b0;
    end else begin
      if (bus.load) begin
        r_reg_b <= r_rd_data;
        if (!r_rd_valid) r_load_err <= 1'b1;
      end
      // Transfer sees the pre-edge RegB even when Load fires in the same cycle.
      if (bus.clear) begin
        r_acc <= '0;
      end else if (bus.transfer) begin
        r_acc <= r_acc + {{(ACC_W-DATA_W){1'b0}}, r_reg_b};
      end
      if (bus.clear) begin
        r_overflow <= 1'b0;
      end else if (bus.write_enable && acc_exceeds(r_acc)) begin
        r_overflow <= 1'b1;
      end
      if (bus.write_enable && bus.init_we) r_init_collide <= 1'b1;
    end
  end

  // ---- memory write: write-back beats the loader ----
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      if (bus.write_enable) begin
        r_mem[bus.address] <= acc_trunc(r_acc);
      end else if (bus.init_we) begin
        r_mem[bus.init_addr] <= bus.init_data;
      end
    end
  end

  assign bus.rd_data      = r_rd_data;
  assign bus.rd_valid     = r_rd_valid;
  assign bus.reg_b        = r_reg_b;
  assign bus.acc          = r_acc;
  assign bus.overflow     = r_overflow;
  assign bus.load_err     = r_load_err;
  assign bus.init_collide = r_init_collide;

endmodule

// File: tb/tb_accum_datapath.sv
// Directed testbench for accum_datapath with an in-bench behavioural model.
module tb_accum_datapath;
  localparam int DATA_W     = 8;
  localparam int ADDR_W     = 5;
  localparam int DEPTH      = 32;
  localparam int RD_LATENCY = 2;
  localparam int ACC_W      = 11;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  accum_datapath_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ACC_W(ACC_W)) bus();

  accum_datapath #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH),
    .RD_LATENCY(RD_LATENCY), .ACC_W(ACC_W)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus(bus)
  );

  int checks   = 0;
  int failures = 0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [DATA_W-1:0] data;
    int                due;
  } rd_req_t;

  rd_req_t           q[$];
  logic [DATA_W-1:0] m_mem [DEPTH];
  logic [DATA_W-1:0] m_rd_data;
  logic              m_rd_valid;
  logic [DATA_W-1:0] m_reg_b;
  logic [ACC_W-1:0]  m_acc;
  logic              m_ovf, m_lerr, m_icol;
  bit                model_on = 0;
  int                cyc = 0;

  always @(posedge clk) begin
    logic [DATA_W-1:0] o_rd_data, o_reg_b;
    logic              o_rd_valid;
    logic [ACC_W-1:0]  o_acc;
    rd_req_t           r;
    bit                done;
    logic [DATA_W-1:0] dd;
    if (rst) begin
      q.delete();
      m_rd_data = '0; m_rd_valid = 0; m_reg_b = '0; m_acc = '0;
      m_ovf = 0; m_lerr = 0; m_icol = 0;
      model_on = 1;
    end else begin
      o_rd_data = m_rd_data; o_rd_valid = m_rd_valid; o_reg_b = m_reg_b; o_acc = m_acc;
      if (bus.read_enable) begin
        r.data = m_mem[bus.address];
        r.due  = cyc + RD_LATENCY - 1;
        q.push_back(r);
      end
      done = 0; dd = '0;
      if (q.size() > 0 && q[0].due == cyc) begin
        done = 1; dd = q[0].data; q.delete(0);
      end
      if (bus.load) begin
        m_reg_b = o_rd_data;
        if (!o_rd_valid) m_lerr = 1;
      end
      if (bus.clear) m_acc = 0;
      else if (bus.transfer) m_acc = ACC_W'(int'(o_acc) + int'(o_reg_b));
      if (bus.clear) m_ovf = 0;
      else if (bus.write_enable && int'(o_acc) >= (1 << DATA_W)) m_ovf = 1;
      if (bus.write_enable && bus.init_we) m_icol = 1;
      if (bus.write_enable) m_mem[bus.address] = o_acc[DATA_W-1:0];
      else if (bus.init_we) m_mem[bus.init_addr] = bus.init_data;
      if (done) begin
        m_rd_data = dd; m_rd_valid = 1;
      end else if (bus.load) begin
        m_rd_valid = 0;
      end
    end
    cyc++;
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (model_on) begin
      cmp("rd_valid", 32'(bus.rd_valid), 32'(m_rd_valid));
      cmp("rd_data", 32'(bus.rd_data), 32'(m_rd_data));
      cmp("reg_b", 32'(bus.reg_b), 32'(m_reg_b));
      cmp("acc", 32'(bus.acc), 32'(m_acc));
      cmp("overflow", 32'(bus.overflow), 32'(m_ovf));
      cmp("load_err", 32'(bus.load_err), 32'(m_lerr));
      cmp("init_collide", 32'(bus.init_collide), 32'(m_icol));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    bus.address = '0; bus.read_enable = 0; bus.load = 0; bus.clear = 0;
    bus.transfer = 0; bus.write_enable = 0; bus.init_we = 0;
    bus.init_addr = '0; bus.init_data = '0;
  endtask

  task automatic init_word(input int a, input int d);
    bus.init_we = 1; bus.init_addr = ADDR_W'(a); bus.init_data = DATA_W'(d);
    tick();
    bus.init_we = 0;
  endtask

  task automatic do_read(input int a);
    bus.address = ADDR_W'(a); bus.read_enable = 1;
    tick();
    bus.read_enable = 0;
    tick();
  endtask

  task automatic load_add(input int a);
    do_read(a);
    bus.load = 1; tick(); bus.load = 0;
    bus.transfer = 1; tick(); bus.transfer = 0;
  endtask

  task automatic pulse_clear();
    bus.clear = 1; tick(); bus.clear = 0;
  endtask

  task automatic write_back(input int a);
    bus.address = ADDR_W'(a); bus.write_enable = 1; tick(); bus.write_enable = 0;
  endtask

  task automatic check_all_zero(input string tag);
    cmp({tag, "_rd_valid"}, 32'(bus.rd_valid), 0);
    cmp({tag, "_rd_data"}, 32'(bus.rd_data), 0);
    cmp({tag, "_reg_b"}, 32'(bus.reg_b), 0);
    cmp({tag, "_acc"}, 32'(bus.acc), 0);
    cmp({tag, "_overflow"}, 32'(bus.overflow), 0);
    cmp({tag, "_load_err"}, 32'(bus.load_err), 0);
    cmp({tag, "_init_collide"}, 32'(bus.init_collide), 0);
  endtask

  initial begin
    idle();
    rst = 1;
    tick(); tick();
    check_all_zero("reset");
    rst = 0;

    // Block of 1..7 summed into word 7
    for (int i = 0; i < 7; i++) init_word(i, i + 1);
    pulse_clear();
    for (int i = 0; i < 7; i++) load_add(i);
    write_back(7);
    cmp("t1_acc", 32'(bus.acc), 28);
    cmp("t1_overflow", 32'(bus.overflow), 0);
    cmp("t1_load_err", 32'(bus.load_err), 0);
    do_read(7);
    cmp("t1_mem7", 32'(bus.rd_data), 28);

    // Block of 0xFF words: wide sum, truncated write-back, overflow
    for (int i = 8; i < 15; i++) init_word(i, 8'hFF);
    pulse_clear();
    for (int i = 8; i < 15; i++) load_add(i);
    write_back(15);
    cmp("t2_acc", 32'(bus.acc), 1785);
    cmp("t2_overflow", 32'(bus.overflow), 1);
    do_read(15);
    cmp("t2_mem15", 32'(bus.rd_data), 8'hF9);
    pulse_clear();
    cmp("t2_clr_acc", 32'(bus.acc), 0);
    cmp("t2_clr_overflow", 32'(bus.overflow), 0);

    // Back-to-back pipelined reads
    init_word(3, 3); init_word(4, 4); init_word(5, 5);
    bus.address = 3; bus.read_enable = 1; tick();
    bus.address = 4; tick();
    cmp("t3_rd0", 32'(bus.rd_data), 3);
    cmp("t3_vld0", 32'(bus.rd_valid), 1);
    bus.address = 5; tick();
    cmp("t3_rd1", 32'(bus.rd_data), 4);
    cmp("t3_vld1", 32'(bus.rd_valid), 1);
    bus.read_enable = 0; tick();
    cmp("t3_rd2", 32'(bus.rd_data), 5);
    cmp("t3_vld2", 32'(bus.rd_valid), 1);

    // Load without a completed read; Clear beats Transfer
    rst = 1; tick(); rst = 0;
    bus.load = 1; tick(); bus.load = 0;
    cmp("t4_reg_b", 32'(bus.reg_b), 0);
    cmp("t4_load_err", 32'(bus.load_err), 1);
    init_word(20, 9);
    load_add(20);
    cmp("t4_acc9", 32'(bus.acc), 9);
    bus.clear = 1; bus.transfer = 1; tick(); bus.clear = 0; bus.transfer = 0;
    cmp("t4_acc0", 32'(bus.acc), 0);
    cmp("t4_reg_b9", 32'(bus.reg_b), 9);

    // Init/write-back collision, then read-before-write
    init_word(21, 5);
    load_add(21);
    bus.address = 2; bus.write_enable = 1;
    bus.init_we = 1; bus.init_addr = 2; bus.init_data = 9;
    tick();
    bus.write_enable = 0; bus.init_we = 0;
    cmp("t5_collide", 32'(bus.init_collide), 1);
    do_read(2);
    cmp("t5_mem2", 32'(bus.rd_data), 5);
    bus.transfer = 1; tick(); bus.transfer = 0;
    cmp("t5_acc10", 32'(bus.acc), 10);
    bus.address = 2; bus.read_enable = 1; bus.write_enable = 1; tick();
    bus.read_enable = 0; bus.write_enable = 0; tick();
    cmp("t5_rbw_old", 32'(bus.rd_data), 5);
    do_read(2);
    cmp("t5_rbw_new", 32'(bus.rd_data), 10);

    // Reset with a read in flight and write strobes active
    init_word(22, 8'h33); init_word(23, 8'h44);
    bus.address = 22; bus.read_enable = 1; tick();
    bus.read_enable = 0;
    rst = 1; bus.write_enable = 1;
    bus.init_we = 1; bus.init_addr = 23; bus.init_data = 8'h77;
    tick();
    check_all_zero("t6");
    idle(); rst = 0;
    tick();
    cmp("t6_vld_after", 32'(bus.rd_valid), 0);
    do_read(22);
    cmp("t6_mem22", 32'(bus.rd_data), 8'h33);
    do_read(23);
    cmp("t6_mem23", 32'(bus.rd_data), 8'h44);

    tick(); tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
